multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main sequencing FSM for the multi-cycle RV64 subset datapath: IF, ID, EX, MEM, WB.
- Drives the 2-bit ALUOp into the ALU control decoder, ALU operand muxes, PC/IR write enables, register-file write and data-memory requests.
- Stalls on a ready-handshake memory and resolves BEQ/BNE from the ALU zero flag.
- Halts on a HALT opcode or on memory timeout.

Parameters:
- TIMEOUT, 64: max consecutive cycles a memory request may wait for i_mem_ready before error-halt (>=2).
- HALT_OPCODE, 7'b1111111: opcode that stops the machine.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_opcode  in  7  IR[6:0], valid from ID onward
- i_funct3  in  3  IR[14:12]; bit0 selects BEQ(0)/BNE(1)
- i_zero  in  1  ALU zero flag, same cycle
- i_mem_ready  in  1  memory completes current request this cycle
- o_ALUOp  out  2  00 add, 01 subtract (branch compare), 10 funct-decoded
- o_ALUSrcA  out  1  0 PC, 1 rs1
- o_ALUSrcB  out  2  00 rs2, 01 constant 4, 10 immediate
- o_pc_write  out  1  PC load enable
- o_pc_src  out  1  0 ALU result, 1 ALUOut register (branch target)
- o_ir_write  out  1  IR load enable
- o_mem_read  out  1  memory read request (instr or data)
- o_mem_write  out  1  memory write request
- o_mem_iord  out  1  0 address from PC, 1 from ALUOut
- o_reg_write  out  1  register-file write enable
- o_mem_to_reg  out  1  WB source: 0 ALUOut, 1 memory data register
- o_illegal  out  1  one-cycle pulse on unsupported opcode
- o_done  out  1  sticky halt indicator
- o_error  out  1  sticky timeout indicator

Behaviour:
- State register only; outputs decoded combinationally from state plus i_mem_ready/i_zero gating.
- While i_rst=1, every enable/pulse output is 0. Next edge loads S_IF, counter 0, o_done=0, o_error=0. Reset mid-operation aborts any pending request; no write is issued in the reset cycle.
- Unlisted outputs are 0 in each state.
- S_IF: mem_read=1, iord=0, SrcA=0, SrcB=01, ALUOp=00.
  - If i_mem_ready: ir_write=1, pc_write=1, pc_src=0, go to S_ID.
  - Otherwise hold S_IF.
- S_ID: SrcA=0, SrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> S_EX_R
  - 0010011 -> S_EX_I
  - 0000011 / 0100011 -> S_ADDR
  - 1100011 -> S_BR
  - HALT_OPCODE -> S_HALT
  - other -> o_illegal=1, go to S_IF
- S_EX_R: SrcA=1, SrcB=00, ALUOp=10 -> S_WB_ALU.
- S_EX_I: SrcA=1, SrcB=10, ALUOp=10 -> S_WB_ALU.
- S_ADDR: SrcA=1, SrcB=10, ALUOp=00 -> S_MEM_RD for load, S_MEM_WR for store. The opcode is re-sampled here; IR is stable.
- S_BR: SrcA=1, SrcB=00, ALUOp=01, pc_src=1. pc_write = i_zero XOR i_funct3[0]. -> S_IF.
- S_MEM_RD: mem_read=1, iord=1. Hold until i_mem_ready, then -> S_WB_MEM.
- S_MEM_WR: mem_write=1, iord=1. Hold until i_mem_ready, then -> S_IF.
- S_WB_ALU: reg_write=1, mem_to_reg=0 -> S_IF.
- S_WB_MEM: reg_write=1, mem_to_reg=1 -> S_IF.
- S_HALT: terminal until reset; o_done=1, all enables 0.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - Each wait cycle adds 1.
- Wait counter:
  - Increments each cycle in S_IF/S_MEM_RD/S_MEM_WR with i_mem_ready=0.
  - Clears on any state change or on ready.
  - Width = clog2(TIMEOUT+1).
  - When it reaches TIMEOUT-1 with ready still 0: go to S_HALT, set o_done=1 and o_error=1; no IR/PC/reg write that cycle.
  - Ready arriving in the same cycle as expiry wins: normal transition, no error.

Decomposition:
- Shared package (cpu_pkg): opcode constants, ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), SrcB encodings, state enum.
- The ALU control decoder consumes the ALUOp constants from the same package.
- One natural sub-module: mem_wait_timer (counter plus expiry flag, parameterised by TIMEOUT).

Test Plan:
- Reset, zero-wait memory, R-type opcode 0110011: states IF,ID,EX_R,WB_ALU in 4 cycles. ALUOp=10 in EX; reg_write=1 only in cycle 4; then IF.
- LD (0000011), i_mem_ready low 3 cycles in MEM_RD: mem_read/iord held 4 cycles, then WB_MEM with mem_to_reg=1. Total 8 cycles.
- BEQ with i_zero=1, then BNE (funct3=001) with i_zero=1: pc_write=1 with pc_src=1 in S_BR for BEQ; pc_write=0 for BNE. Both return to IF after 3 cycles.
- Opcode 0001111 in ID: o_illegal single pulse, no reg_write/mem_write, next cycle IF. Then opcode 1111111: o_done=1 and stays 1 with all enables 0 for 20 cycles.
- TIMEOUT=4, i_mem_ready stuck 0 in IF: after 4 cycles go to S_HALT with o_error=1, o_done=1, ir_write never asserted. Repeat with ready on cycle 4: normal fetch, o_error=0.
- Assert i_rst during S_MEM_WR with ready low: mem_write=0 in the reset cycle; state S_IF after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV64 subset core: opcodes,
// ALUOp / operand-B select values and the control FSM state set.
package cpu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_EX_R,
    S_EX_I,
    S_ADDR,
    S_BR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_HALT
  } state_t;

  // States that issue a memory request and may stall on ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags expiry on the
// TIMEOUT-th stalled cycle. Ports: i_clk, i_rst, i_wait, o_expired.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wait,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_expired = i_wait && (cnt_q == LAST);

  // Any cycle that is not a stall (ready, or another state) clears.
  assign cnt_d = (i_wait && !o_expired) ? cnt_q + W'(1) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main IF/ID/EX/MEM/WB sequencing FSM of the multi-cycle datapath.
// Ports: opcode/funct3/zero/mem_ready in; mux selects, enables,
// memory requests and illegal/done/error status out.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int         TIMEOUT     = 64,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [1:0] o_ALUOp,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic       o_ir_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_iord,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_illegal,
  output logic       o_done,
  output logic       o_error
);

  state_t state_q, state_d;
  logic   err_q;
  logic   expired;
  logic   stall;

  logic pc_write, ir_write, mem_read, mem_write;
  logic reg_write, illegal;

  logic unused_funct3;
  assign unused_funct3 = ^i_funct3[2:1];

  assign stall = is_wait_state(state_q) && !i_mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wait    (stall),
    .o_expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    o_ALUOp      = ALUOP_ADD;
    o_ALUSrcA    = 1'b0;
    o_ALUSrcB    = SRCB_RS2;
    o_pc_src     = 1'b0;
    o_mem_iord   = 1'b0;
    o_mem_to_reg = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        o_ALUSrcB = SRCB_FOUR;
        if (i_mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end else if (expired) begin
          state_d = S_HALT;
        end
      end
      S_ID: begin
        o_ALUSrcB = SRCB_IMM;
        case (i_opcode)
          OP_RTYPE:            state_d = S_EX_R;
          OP_ITYPE:            state_d = S_EX_I;
          OP_LOAD, OP_STORE:   state_d = S_ADDR;
          OP_BRANCH:           state_d = S_BR;
          HALT_OPCODE:         state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp   = ALUOP_FUNCT;
        state_d   = S_WB_ALU;
      end
      S_EX_I: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = ALUOP_FUNCT;
        state_d   = S_WB_ALU;
      end
      S_ADDR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
        state_d   = (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_BR: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp   = ALUOP_SUB;
        o_pc_src  = 1'b1;
        // funct3[0] inverts the sense: BEQ takes on zero, BNE on nonzero.
        pc_write  = i_zero ^ i_funct3[0];
        state_d   = S_IF;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        o_mem_iord = 1'b1;
        if (i_mem_ready)  state_d = S_WB_MEM;
        else if (expired) state_d = S_HALT;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        o_mem_iord = 1'b1;
        if (i_mem_ready)  state_d = S_IF;
        else if (expired) state_d = S_HALT;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_WB_MEM: begin
        reg_write    = 1'b1;
        o_mem_to_reg = 1'b1;
        state_d      = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset suppresses every side effect in the cycle it is applied.
  assign o_pc_write  = pc_write  && !i_rst;
  assign o_ir_write  = ir_write  && !i_rst;
  assign o_mem_read  = mem_read  && !i_rst;
  assign o_mem_write = mem_write && !i_rst;
  assign o_reg_write = reg_write && !i_rst;
  assign o_illegal   = illegal   && !i_rst;
  assign o_done      = (state_q == S_HALT);
  assign o_error     = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (expired) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (TIMEOUT=4).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic [1:0] o_ALUOp;
  logic       o_ALUSrcA;
  logic [1:0] o_ALUSrcB;
  logic       o_pc_write, o_pc_src, o_ir_write, o_mem_read;
  logic       o_mem_write, o_mem_iord, o_reg_write, o_mem_to_reg;
  logic       o_illegal, o_done, o_error;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready),
    .o_ALUOp(o_ALUOp), .o_ALUSrcA(o_ALUSrcA),
    .o_ALUSrcB(o_ALUSrcB), .o_pc_write(o_pc_write),
    .o_pc_src(o_pc_src), .o_ir_write(o_ir_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_iord(o_mem_iord), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_illegal(o_illegal),
    .o_done(o_done), .o_error(o_error)
  );

  logic [15:0] obs;
  assign obs = {o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_pc_write,
                o_pc_src, o_ir_write, o_mem_read, o_mem_write,
                o_mem_iord, o_reg_write, o_mem_to_reg, o_illegal,
                o_done, o_error};

  localparam logic [15:0] F_SUB  = 16'h4000;
  localparam logic [15:0] F_FN   = 16'h8000;
  localparam logic [15:0] F_SRCA = 16'h2000;
  localparam logic [15:0] F_IMM  = 16'h1000;
  localparam logic [15:0] F_FOUR = 16'h0800;
  localparam logic [15:0] F_PCW  = 16'h0400;
  localparam logic [15:0] F_PCS  = 16'h0200;
  localparam logic [15:0] F_IRW  = 16'h0100;
  localparam logic [15:0] F_MRD  = 16'h0080;
  localparam logic [15:0] F_MWR  = 16'h0040;
  localparam logic [15:0] F_IORD = 16'h0020;
  localparam logic [15:0] F_REGW = 16'h0010;
  localparam logic [15:0] F_M2R  = 16'h0008;
  localparam logic [15:0] F_ILL  = 16'h0004;
  localparam logic [15:0] F_DONE = 16'h0002;
  localparam logic [15:0] F_ERR  = 16'h0001;
  localparam logic [15:0] ALL    = 16'hFFFF;

  localparam logic [15:0] E_IFW  = F_FOUR | F_MRD;
  localparam logic [15:0] E_IFR  = E_IFW | F_PCW | F_IRW;
  localparam logic [15:0] E_ID   = F_IMM;
  localparam logic [15:0] E_EXR  = F_FN | F_SRCA;
  localparam logic [15:0] E_EXI  = F_FN | F_SRCA | F_IMM;
  localparam logic [15:0] E_ADDR = F_SRCA | F_IMM;
  localparam logic [15:0] E_BRN  = F_SUB | F_SRCA | F_PCS;
  localparam logic [15:0] E_BRT  = E_BRN | F_PCW;
  localparam logic [15:0] E_MRD  = F_MRD | F_IORD;
  localparam logic [15:0] E_MWR  = F_MWR | F_IORD;
  localparam logic [15:0] E_WBA  = F_REGW;
  localparam logic [15:0] E_WBM  = F_REGW | F_M2R;
  localparam logic [15:0] E_ILL  = F_IMM | F_ILL;
  localparam logic [15:0] E_HLT  = F_DONE;
  localparam logic [15:0] E_HLTE = F_DONE | F_ERR;
  localparam logic [15:0] M_RST  = F_PCW | F_IRW | F_MRD | F_MWR
                                 | F_REGW | F_ILL;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] FN = 7'b0001111;
  localparam logic [6:0] HT = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [15:0] exp;
    logic [15:0] mask;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic rst, input logic [6:0] op,
                     input logic [2:0] f3, input logic z,
                     input logic rdy, input logic [15:0] exp,
                     input logic [15:0] mask, input string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy;
    v.exp = exp; v.mask = mask; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic z,
                      input logic rdy, input logic [15:0] exp,
                      input logic [15:0] mask, input string nm);
    i_rst = rst; i_opcode = op; i_funct3 = f3;
    i_zero = z; i_mem_ready = rdy;
    #2;
    checks++;
    if ((obs & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm,
               obs & mask, exp & mask);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then R-type with zero-wait memory
    add(1, R, 0, 0, 0, 16'h0, M_RST, "rst0");
    add(1, R, 0, 0, 1, 16'h0, M_RST, "rst1");
    add(0, R, 0, 0, 1, E_IFR, ALL, "r_if");
    add(0, R, 0, 0, 1, E_ID,  ALL, "r_id");
    add(0, R, 0, 0, 1, E_EXR, ALL, "r_ex");
    add(0, R, 0, 0, 1, E_WBA, ALL, "r_wb");
    // I-type
    add(0, I, 0, 0, 1, E_IFR, ALL, "i_if");
    add(0, I, 0, 0, 1, E_ID,  ALL, "i_id");
    add(0, I, 0, 0, 1, E_EXI, ALL, "i_ex");
    add(0, I, 0, 0, 1, E_WBA, ALL, "i_wb");
    // Load with three wait cycles in MEM_RD: 8 cycles total
    add(0, LD, 0, 0, 1, E_IFR,  ALL, "ld_if");
    add(0, LD, 0, 0, 1, E_ID,   ALL, "ld_id");
    add(0, LD, 0, 0, 1, E_ADDR, ALL, "ld_addr");
    add(0, LD, 0, 0, 0, E_MRD,  ALL, "ld_w1");
    add(0, LD, 0, 0, 0, E_MRD,  ALL, "ld_w2");
    add(0, LD, 0, 0, 0, E_MRD,  ALL, "ld_w3");
    add(0, LD, 0, 0, 1, E_MRD,  ALL, "ld_rdy");
    add(0, LD, 0, 0, 1, E_WBM,  ALL, "ld_wb");
    // Store, zero-wait
    add(0, SD, 0, 0, 1, E_IFR,  ALL, "sd_if");
    add(0, SD, 0, 0, 1, E_ID,   ALL, "sd_id");
    add(0, SD, 0, 0, 1, E_ADDR, ALL, "sd_addr");
    add(0, SD, 0, 0, 1, E_MWR,  ALL, "sd_mem");
    // BEQ z=1 taken, BNE z=1 not taken, BEQ z=0, BNE z=0
    add(0, BR, 0, 1, 1, E_IFR, ALL, "beq_if");
    add(0, BR, 0, 1, 1, E_ID,  ALL, "beq_id");
    add(0, BR, 0, 1, 1, E_BRT, ALL, "beq_z1");
    add(0, BR, 1, 1, 1, E_IFR, ALL, "bne_if");
    add(0, BR, 1, 1, 1, E_ID,  ALL, "bne_id");
    add(0, BR, 1, 1, 1, E_BRN, ALL, "bne_z1");
    add(0, BR, 0, 0, 1, E_IFR, ALL, "beq0_if");
    add(0, BR, 0, 0, 1, E_ID,  ALL, "beq0_id");
    add(0, BR, 0, 0, 1, E_BRN, ALL, "beq_z0");
    add(0, BR, 1, 0, 1, E_IFR, ALL, "bne0_if");
    add(0, BR, 1, 0, 1, E_ID,  ALL, "bne0_id");
    add(0, BR, 1, 0, 1, E_BRT, ALL, "bne_z0");
    // Illegal opcode: single pulse, back to IF
    add(0, FN, 0, 0, 1, E_IFR, ALL, "ill_if");
    add(0, FN, 0, 0, 1, E_ILL, ALL, "ill_id");
    add(0, FN, 0, 0, 0, E_IFW, ALL, "ill_next");
    add(0, HT, 0, 0, 1, E_IFR, ALL, "ht_if");
    add(0, HT, 0, 0, 1, E_ID,  ALL, "ht_id");

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].z,
           tbl[i].rdy, tbl[i].exp, tbl[i].mask, tbl[i].nm);

    // Halt holds for 20 cycles regardless of inputs
    for (int k = 0; k < 20; k++)
      step(0, R, 3'(k), k[0], k[1], E_HLT, ALL, "halt_hold");

    // Fetch timeout: 4 stalled cycles then error-halt
    step(1, R, 0, 0, 0, 16'h0, M_RST, "to_rst");
    for (int k = 0; k < 4; k++)
      step(0, R, 0, 0, 0, E_IFW, ALL, "to_wait");
    for (int k = 0; k < 3; k++)
      step(0, R, 0, 0, 1, E_HLTE, ALL, "to_halt");

    // Ready on the expiry cycle wins
    step(1, R, 0, 0, 0, 16'h0, M_RST, "tr_rst");
    for (int k = 0; k < 3; k++)
      step(0, R, 0, 0, 0, E_IFW, ALL, "tr_wait");
    step(0, R, 0, 0, 1, E_IFR, ALL, "tr_fetch");
    step(0, R, 0, 0, 1, E_ID,  ALL, "tr_id");
    step(0, R, 0, 0, 1, E_EXR, ALL, "tr_ex");

    // Reset during a stalled store
    step(0, R,  0, 0, 1, E_WBA,  ALL, "mw_prev");
    step(0, SD, 0, 0, 1, E_IFR,  ALL, "mw_if");
    step(0, SD, 0, 0, 1, E_ID,   ALL, "mw_id");
    step(0, SD, 0, 0, 1, E_ADDR, ALL, "mw_addr");
    step(0, SD, 0, 0, 0, E_MWR,  ALL, "mw_wait");
    step(1, SD, 0, 0, 0, 16'h0,  M_RST, "mw_rst");
    step(0, SD, 0, 0, 0, E_IFW,  ALL, "mw_after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
